router_fsm: RTL and testbench
=============================

// Module: router_fsm
// PURPOSE
//  Packet-ingress control FSM of the 1x3 router. Watches the serial byte stream
//  (pkt_valid + header address bits) and sequences header/payload/parity loading.
//  Drives the input register stage and the per-port FIFOs (write_enb_reg, lfd_state).
//  Stalls on FIFO full, waits for a busy destination to drain, and honours per-port
//  soft resets.
// PARAMETERS
//  NUM_PORTS  3  output ports; header address values >= NUM_PORTS are invalid (dropped)
//  ADDR_W     2  width of header destination field (data_in[1:0])
// PORTS
//  clock          in   1          rising-edge clock
//  resetn         in   1          asynchronous, active-low reset
//  pkt_valid      in   1          source asserts for header+payload bytes; low on parity byte
//  data_in        in   ADDR_W     header destination bits (data_in[1:0] of the header byte)
//  fifo_full      in   1          full flag of the currently selected FIFO
//  fifo_empty     in   NUM_PORTS  per-port FIFO empty flags
//  soft_reset     in   NUM_PORTS  per-port timeout soft reset, 1-cycle pulse
//  parity_done    in   1          register stage has captured the parity byte
//  low_pkt_valid  in   1          register stage saw pkt_valid fall while stalled
//  addr_q         out  ADDR_W     latched destination of the packet in flight
//  detect_add     out  1          FSM in DECODE_ADDRESS
//  lfd_state      out  1          FSM in LOAD_FIRST_DATA (header byte; FIFO tags bit 8)
//  ld_state       out  1          FSM in LOAD_DATA
//  laf_state      out  1          FSM in LOAD_AFTER_FULL
//  full_state     out  1          FSM in FIFO_FULL_STATE
//  write_enb_reg  out  1          register stage pushes a byte to the FIFO this cycle
//  rst_int_reg    out  1          FSM in CHECK_PARITY_ERROR
//  busy           out  1          source must hold its current byte
// BEHAVIOUR
//  - Reset (resetn=0, async): state=DA, addr_q=0; outputs: detect_add=1, all others 0.
//  - State register and addr_q are the only flops; all outputs are Moore decodes of state
//    (0-cycle latency from state).
//  - States: DA, LFD, LD, FFS, LAF, LP, CPE, WTE (3-bit encoding).
//  - DA: if pkt_valid && data_in<NUM_PORTS: latch addr_q<=data_in; next = LFD when
//    fifo_empty[data_in], else WTE. Invalid address or !pkt_valid: stay in DA, addr_q held.
//  - WTE: -> LFD when fifo_empty[addr_q]; else stay.
//  - LFD: -> LD unconditionally (exactly one cycle).
//  - LD: fifo_full -> FFS; else !pkt_valid -> LP; else stay. fifo_full has priority.
//  - FFS: -> LAF when !fifo_full; else stay.
//  - LAF: parity_done -> DA; else low_pkt_valid -> LP; else -> LD.
//  - LP: -> CPE unconditionally.
//  - CPE: fifo_full -> FFS; else -> DA.
//  - soft_reset[addr_q]=1 in any state other than DA: next state = DA; overrides all
//    other transitions. soft_reset on other ports is ignored. In DA soft_reset is ignored
//    and normal DA decode applies.
//  - Output decode:
//      write_enb_reg = LD|LAF|LP
//      busy          = LFD|FFS|LAF|LP|CPE|WTE (busy=0 in DA and LD)
//  - Back-to-back packets: CPE->DA->LFD is allowed with no idle cycle if the next
//    header is valid in DA.
// STRUCTURE
//  - router_pkg:
//      state encodings (ST_DA..ST_WTE)
//      NUM_PORTS, ADDR_W
//      ADDR_INVALID = 2'b11
//  - Single module: next-state always_comb, async-reset state/addr_q flops, output decode.
//    No sub-module; the block is too small to split usefully.
// TESTING
//  1. Reset mid-packet (state LD): drop resetn async
//     -> detect_add=1, busy=0, write_enb_reg=0 before the next clock edge.
//  2. Header 8'h0D (addr 1), fifo_empty=3'b111, 3 payload bytes
//     -> states DA,LFD,LD,LD,LD,LP,CPE,DA; lfd_state high one cycle; write_enb_reg high 4 cycles.
//  3. Header addr 2 with fifo_empty[2]=0 for 5 cycles
//     -> WTE for 5 cycles, busy=1; LFD on the cycle after fifo_empty[2] rises.
//  4. fifo_full=1 during LD for 3 cycles, then 0 with parity_done=0 and low_pkt_valid=1
//     -> FFS x3 (write_enb_reg=0), LAF, LP, CPE.
//  5. soft_reset=3'b010 while addr_q=1 in FFS -> DA next edge.
//     soft_reset=3'b100 in the same state -> stays in FFS.
//  6. Header addr 3 with pkt_valid=1 -> remains in DA, addr_q unchanged, no write_enb_reg pulse.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router ingress FSM: port count, address width and state encodings.
package router_pkg;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned ADDR_W    = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_DA  = 3'd0,
        ST_LFD = 3'd1,
        ST_LD  = 3'd2,
        ST_FFS = 3'd3,
        ST_LAF = 3'd4,
        ST_LP  = 3'd5,
        ST_CPE = 3'd6,
        ST_WTE = 3'd7
    } state_e;

    // Header destinations at or above the port count are dropped in DA.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < NUM_PORTS;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-ingress control FSM of the 1x3 router: sequences header, payload and parity loading,
// stalls on FIFO full, waits for a busy destination and honours per-port soft resets.
module router_fsm
    import router_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic [ADDR_W-1:0]    addr_q,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic                 busy
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_DA: begin
                if (pkt_valid && addr_valid(data_in)) begin
                    addr_d  = data_in;
                    state_d = fifo_empty[data_in] ? ST_LFD : ST_WTE;
                end
            end
            ST_WTE:  if (fifo_empty[addr_q]) state_d = ST_LFD;
            ST_LFD:  state_d = ST_LD;
            ST_LD: begin
                if (fifo_full)       state_d = ST_FFS;
                else if (!pkt_valid) state_d = ST_LP;
            end
            ST_FFS:  if (!fifo_full) state_d = ST_LAF;
            ST_LAF: begin
                if (parity_done)        state_d = ST_DA;
                else if (low_pkt_valid) state_d = ST_LP;
                else                    state_d = ST_LD;
            end
            ST_LP:   state_d = ST_CPE;
            ST_CPE:  state_d = fifo_full ? ST_FFS : ST_DA;
        endcase
        // A timeout on the in-flight destination aborts the packet from any active state.
        if (state_q != ST_DA && soft_reset[addr_q]) state_d = ST_DA;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_DA;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign detect_add    = (state_q == ST_DA);
    assign lfd_state     = (state_q == ST_LFD);
    assign ld_state      = (state_q == ST_LD);
    assign laf_state     = (state_q == ST_LAF);
    assign full_state    = (state_q == ST_FFS);
    assign rst_int_reg   = (state_q == ST_CPE);
    assign write_enb_reg = ld_state | laf_state | (state_q == ST_LP);
    assign busy          = !(detect_add | ld_state);

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: vector table, directed corner cases and random stimulus
// compared against a phase-level model of the packet protocol.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [1:0] addr_q;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    router_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .addr_q        (addr_q),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Observed output vector: {detect,lfd,ld,laf,full,wen,rst_int,busy}
    logic [7:0] obs;
    assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  write_enb_reg, rst_int_reg, busy};

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %b required %b", name, $time, act, exp);
    endtask

    // Reference model: tracks where the packet is in the protocol, not the RTL encoding.
    typedef enum int {P_IDLE, P_HEADER, P_PAYLOAD, P_STALL, P_RESUME, P_PARITY, P_CHECK,
                      P_WAIT} phase_t;
    phase_t     m_ph   = P_IDLE;
    logic [1:0] m_addr = 2'd0;

    function automatic logic [7:0] model_out(input phase_t ph);
        logic [7:0] v;
        v[7] = (ph == P_IDLE);
        v[6] = (ph == P_HEADER);
        v[5] = (ph == P_PAYLOAD);
        v[4] = (ph == P_RESUME);
        v[3] = (ph == P_STALL);
        v[2] = (ph == P_PAYLOAD) || (ph == P_RESUME) || (ph == P_PARITY);
        v[1] = (ph == P_CHECK);
        v[0] = !((ph == P_IDLE) || (ph == P_PAYLOAD));
        return v;
    endfunction

    task automatic tick();
        phase_t     nph = m_ph;
        logic [1:0] nad = m_addr;
        if (m_ph != P_IDLE && soft_reset[m_addr]) nph = P_IDLE;
        else begin
            case (m_ph)
                P_IDLE:    if (pkt_valid && data_in <= 2'd2) begin
                               nad = data_in;
                               nph = fifo_empty[data_in] ? P_HEADER : P_WAIT;
                           end
                P_WAIT:    if (fifo_empty[m_addr]) nph = P_HEADER;
                P_HEADER:  nph = P_PAYLOAD;
                P_PAYLOAD: nph = fifo_full ? P_STALL : (!pkt_valid ? P_PARITY : P_PAYLOAD);
                P_STALL:   if (!fifo_full) nph = P_RESUME;
                P_RESUME:  nph = parity_done ? P_IDLE : (low_pkt_valid ? P_PARITY : P_PAYLOAD);
                P_PARITY:  nph = P_CHECK;
                P_CHECK:   nph = fifo_full ? P_STALL : P_IDLE;
                default:   nph = P_IDLE;
            endcase
        end
        @(posedge clock);
        #1;
        m_ph   = nph;
        m_addr = nad;
        chk("model_out", obs, model_out(m_ph));
        chk("model_addr", {6'd0, addr_q}, {6'd0, m_addr});
    endtask

    task automatic drive(input logic pv, input logic [1:0] d, input logic ff,
                         input logic [2:0] fe, input logic [2:0] sr, input logic pd,
                         input logic lpv);
        pkt_valid = pv; data_in = d; fifo_full = ff; fifo_empty = fe;
        soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
    endtask

    typedef struct {
        logic       pv;
        logic [1:0] d;
        logic       ff;
        logic [2:0] fe;
        logic [7:0] exp_out;
        logic [1:0] exp_addr;
    } vec_t;

    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0100;
    localparam logic [7:0] O_LP  = 8'b0000_0101;
    localparam logic [7:0] O_CPE = 8'b0000_0011;
    localparam logic [7:0] O_WTE = 8'b0000_0001;
    localparam logic [7:0] O_FFS = 8'b0000_1001;
    localparam logic [7:0] O_LAF = 8'b0001_0101;

    vec_t vecs[19];

    initial begin
        // Packet to port 1, invalid header, then back-to-back packets to ports 0 and 2.
        vecs[0]  = '{1'b1, 2'd1, 1'b0, 3'b111, O_LFD, 2'd1};
        vecs[1]  = '{1'b1, 2'd1, 1'b0, 3'b111, O_LD,  2'd1};
        vecs[2]  = '{1'b1, 2'd1, 1'b0, 3'b111, O_LD,  2'd1};
        vecs[3]  = '{1'b1, 2'd1, 1'b0, 3'b111, O_LD,  2'd1};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 3'b111, O_LP,  2'd1};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 3'b111, O_CPE, 2'd1};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 3'b111, O_DA,  2'd1};
        vecs[7]  = '{1'b1, 2'd3, 1'b0, 3'b111, O_DA,  2'd1};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 3'b111, O_DA,  2'd1};
        vecs[9]  = '{1'b1, 2'd0, 1'b0, 3'b111, O_LFD, 2'd0};
        vecs[10] = '{1'b1, 2'd0, 1'b0, 3'b111, O_LD,  2'd0};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 3'b111, O_LP,  2'd0};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 3'b111, O_CPE, 2'd0};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 3'b111, O_DA,  2'd0};
        vecs[14] = '{1'b1, 2'd2, 1'b0, 3'b111, O_LFD, 2'd2};
        vecs[15] = '{1'b0, 2'd2, 1'b0, 3'b111, O_LD,  2'd2};
        vecs[16] = '{1'b0, 2'd2, 1'b0, 3'b111, O_LP,  2'd2};
        vecs[17] = '{1'b0, 2'd2, 1'b0, 3'b111, O_CPE, 2'd2};
        vecs[18] = '{1'b0, 2'd2, 1'b0, 3'b111, O_DA,  2'd2};

        resetn = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk("reset_out", obs, O_DA);
        chk("reset_addr", {6'd0, addr_q}, 8'd0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].pv, vecs[i].d, vecs[i].ff, vecs[i].fe, 3'b000, 1'b0, 1'b0);
            tick();
            chk($sformatf("vec%0d_out", i), obs, vecs[i].exp_out);
            chk($sformatf("vec%0d_addr", i), {6'd0, addr_q}, {6'd0, vecs[i].exp_addr});
        end

        // Asynchronous reset while in LD.
        drive(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        chk("pre_reset_ld", obs, O_LD);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_out", obs, O_DA);
        chk("async_reset_addr", {6'd0, addr_q}, 8'd0);
        m_ph = P_IDLE;
        m_addr = 2'd0;
        @(posedge clock);
        #1 resetn = 1'b1;

        // Destination 2 busy for 5 cycles, then stall on full and resume into parity.
        drive(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("wte%0d", i), obs, O_WTE);
        end
        fifo_empty = 3'b111;
        tick();
        chk("wte_to_lfd", obs, O_LFD);
        tick();
        chk("lfd_to_ld", obs, O_LD);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ffs%0d", i), obs, O_FFS);
        end
        fifo_full = 1'b0;
        low_pkt_valid = 1'b1;
        pkt_valid = 1'b0;
        tick();
        chk("ffs_to_laf", obs, O_LAF);
        tick();
        chk("laf_to_lp", obs, O_LP);
        tick();
        chk("lp_to_cpe", obs, O_CPE);
        low_pkt_valid = 1'b0;
        tick();
        chk("cpe_to_da", obs, O_DA);

        // Soft reset only acts on the latched destination.
        drive(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        fifo_full = 1'b1;
        tick();
        chk("sr_enter_ffs", obs, O_FFS);
        soft_reset = 3'b100;
        tick();
        chk("sr_other_port", obs, O_FFS);
        soft_reset = 3'b010;
        tick();
        chk("sr_own_port", obs, O_DA);
        soft_reset = 3'b000;
        fifo_full = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            fifo_empty    = 3'($urandom_range(0, 7));
            soft_reset    = ($urandom_range(0, 15) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 1) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
